// File: rtl/sha256_mem_responder.sv
// sha256_mem_responder: word SRAM and run sequencer for the simplified_sha256 hasher.
//   Owns the message/digest memory, answers hasher requests with 1-cycle read latency,
//   lets the host preload words while idle, launches a run and reads the 8-word digest back.
//   Optional feature macro: SHA_RESP_SCRUB_EN (zero the digest region before every run).
// Ports:
//   clk, reset                     clock, async active-high reset
//   host_we/host_addr/host_wdata   host write port (honoured only in IDLE)
//   go                             run request (sampled only in IDLE)
//   busy, digest, digest_valid     run status and 256-bit result (h0 in [255:224])
//   timeout, addr_err              sticky error flags
//   sha_start, sha_message_addr, sha_output_addr, sha_done   hasher control
//   mem_we/mem_addr/mem_write_data, mem_read_data            hasher memory port
module sha256_mem_responder #(
   parameter int          DEPTH    = 256,
   parameter logic [15:0] MSG_BASE = 16'h0000,
   parameter logic [15:0] OUT_BASE = 16'h0040,
   parameter int          TIMEOUT  = 4096
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         host_we,
   input  logic [15:0]  host_addr,
   input  logic [31:0]  host_wdata,
   input  logic         go,
   output logic         busy,
   output logic [255:0] digest,
   output logic         digest_valid,
   output logic         timeout,
   output logic         addr_err,
   output logic         sha_start,
   output logic [15:0]  sha_message_addr,
   output logic [15:0]  sha_output_addr,
   input  logic         sha_done,
   input  logic         mem_we,
   input  logic [15:0]  mem_addr,
   input  logic [31:0]  mem_write_data,
   output logic [31:0]  mem_read_data
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {S_IDLE, S_SCRUB, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_READBACK} state_t;
   state_t        r_state;
   logic [3:0]    r_cnt;
   logic [TW-1:0] r_tmo;
   logic [31:0]   r_mem [DEPTH];
   logic          w_host, w_sha, w_seq, w_req, w_we, w_ok;
   logic [15:0]   w_addr;
   logic [31:0]   w_wdata;
   logic [AW-1:0] w_idx;
   // Port ownership: host in IDLE, hasher while waiting, sequencer while scrubbing/reading back.
   // READBACK issues reads only for r_cnt 0..7; the 9th cycle is capture-only.
   assign w_host  = r_state == S_IDLE;
   assign w_sha   = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
   assign w_seq   = (r_state == S_SCRUB) || ((r_state == S_READBACK) && !r_cnt[3]);
   assign w_req   = (w_host && host_we) || w_sha || w_seq;
   assign w_we    = w_host || (w_sha && mem_we) || (r_state == S_SCRUB);
   assign w_addr  = w_host ? host_addr : w_sha ? mem_addr : OUT_BASE + {12'd0, r_cnt};
   assign w_wdata = w_host ? host_wdata : w_sha ? mem_write_data : '0;
   assign w_ok    = {16'd0, w_addr} < 32'(DEPTH);
   assign w_idx   = w_addr[AW-1:0];
   assign busy             = r_state != S_IDLE;
   assign sha_message_addr = MSG_BASE;
   assign sha_output_addr  = OUT_BASE;
   // Memory array is deliberately not reset so contents survive a reset.
   always_ff @(posedge clk) begin
      if (w_req && w_we && w_ok) r_mem[w_idx] <= w_wdata;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_tmo         <= '0;
         digest        <= '0;
         digest_valid  <= 1'b0;
         timeout       <= 1'b0;
         addr_err      <= 1'b0;
         sha_start     <= 1'b0;
         mem_read_data <= '0;
      end else begin
         sha_start <= 1'b0;
         // Read data only moves on read cycles; a write leaves the old value visible.
         if (w_req && !w_we) mem_read_data <= w_ok ? r_mem[w_idx] : '0;
         if (w_req && !w_ok) addr_err <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (go) begin
                  r_cnt <= '0;
`ifdef SHA_RESP_SCRUB_EN
                  r_state <= S_SCRUB;
`else
                  r_state <= S_START;
`endif
               end
            end
            S_SCRUB: begin
               r_cnt <= r_cnt + 4'd1;
               if (r_cnt == 4'd7) r_state <= S_START;
            end
            S_START: begin
               sha_start    <= 1'b1;
               digest_valid <= 1'b0;
               timeout      <= 1'b0;
               r_tmo        <= TW'(TIMEOUT);
               r_state      <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY, S_WAIT_DONE: begin
               if (r_tmo == '0) begin
                  timeout <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_tmo <= r_tmo - 1'b1;
                  if (r_state == S_WAIT_BUSY && !sha_done) r_state <= S_WAIT_DONE;
                  if (r_state == S_WAIT_DONE && sha_done) begin
                     r_cnt   <= '0;
                     r_state <= S_READBACK;
                  end
               end
            end
            S_READBACK: begin
               // Word k arrives one cycle after its address, so capture lags issue by one.
               if (r_cnt != 4'd0) digest <= {digest[223:0], mem_read_data};
               if (r_cnt == 4'd8) begin
                  digest_valid <= 1'b1;
                  r_state      <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sha256_mem_responder.sv
// tb_sha256_mem_responder: directed self-checking bench with a behavioural SHA-256 hasher.
module tb_sha256_mem_responder;
   localparam logic [15:0] MSG_BASE = 16'h0000;
   localparam logic [15:0] OUT_BASE = 16'h0040;
`ifdef SHA_RESP_SCRUB_EN
   localparam int SCRUB_CYC = 8;
   localparam logic [255:0] STALE_EXP = '0;
`else
   localparam int SCRUB_CYC = 0;
   localparam logic [255:0] STALE_EXP = {8{32'hFFFFFFFF}};
`endif
   localparam logic [255:0] ABC_EXP = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                       32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
   localparam logic [31:0] H0 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   logic         clk = 1'b0;
   logic         reset, host_we, go, sha_done, mem_we, go_t;
   logic [15:0]  host_addr, mem_addr;
   logic [31:0]  host_wdata, mem_write_data;
   logic         busy, digest_valid, timeout, addr_err, sha_start;
   logic [255:0] digest;
   logic [15:0]  sha_message_addr, sha_output_addr;
   logic [31:0]  mem_read_data;
   logic         t_busy, t_digest_valid, t_timeout, t_addr_err, t_sha_start;
   logic [255:0] t_digest;
   logic [15:0]  t_msg_addr, t_out_addr;
   logic [31:0]  t_mem_read_data;
   int           n_run = 0, n_fail = 0, n_start = 0, cnt, n0;

   sha256_mem_responder dut (
      .clk(clk), .reset(reset), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .go(go), .busy(busy), .digest(digest), .digest_valid(digest_valid), .timeout(timeout),
      .addr_err(addr_err), .sha_start(sha_start), .sha_message_addr(sha_message_addr),
      .sha_output_addr(sha_output_addr), .sha_done(sha_done), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data));

   sha256_mem_responder #(.TIMEOUT(16)) dut_t (
      .clk(clk), .reset(reset), .host_we(1'b0), .host_addr(16'h0000), .host_wdata(32'h0),
      .go(go_t), .busy(t_busy), .digest(t_digest), .digest_valid(t_digest_valid), .timeout(t_timeout),
      .addr_err(t_addr_err), .sha_start(t_sha_start), .sha_message_addr(t_msg_addr),
      .sha_output_addr(t_out_addr), .sha_done(1'b1), .mem_we(1'b0), .mem_addr(16'h0000),
      .mem_write_data(32'h0), .mem_read_data(t_mem_read_data));

   always #5 clk = ~clk;
   always @(posedge clk) if (sha_start) n_start++;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic hw(input logic [15:0] a, input logic [31:0] d);
      host_we = 1'b1; host_addr = a; host_wdata = d;
      @(negedge clk);
      host_we = 1'b0;
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha_blk(input logic [31:0] m [16]);
      logic [31:0] w [64];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      for (int t = 0; t < 64; t++)
         w[t] = (t < 16) ? m[t] : w[t-16] + w[t-7]
              + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3))
              + (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10));
      a = H0[0]; b = H0[1]; c = H0[2]; d = H0[3]; e = H0[4]; f = H0[5]; g = H0[6]; h = H0[7];
      for (int t = 0; t < 64; t++) begin
         t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
         t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      return {H0[0] + a, H0[1] + b, H0[2] + c, H0[3] + d, H0[4] + e, H0[5] + f, H0[6] + g, H0[7] + h};
   endfunction

   // Behavioural hasher: entered on the negedge where sha_start is seen high.
   task automatic run_hash(input bit pulse_go);
      logic [31:0]  m [16];
      logic [255:0] hv;
      sha_done = 1'b0;
      mem_we   = 1'b0;
      for (int i = 0; i <= 16; i++) begin
         if (i > 0) m[i-1] = mem_read_data;
         if (i < 16) mem_addr = MSG_BASE + 16'(i);
         if (pulse_go) go = (i == 3);
         @(negedge clk);
      end
      go = 1'b0;
      hv = sha_blk(m);
      for (int j = 0; j < 8; j++) begin
         mem_we = 1'b1; mem_addr = OUT_BASE + 16'(j); mem_write_data = hv[255-32*j -: 32];
         @(negedge clk);
      end
      mem_we   = 1'b0;
      sha_done = 1'b1;
   endtask

   initial begin
      reset = 1'b1; host_we = 1'b0; host_addr = '0; host_wdata = '0; go = 1'b0; go_t = 1'b0;
      sha_done = 1'b1; mem_we = 1'b0; mem_addr = '0; mem_write_data = '0;
      @(negedge clk); @(negedge clk);
      chk("rst_busy", 256'(busy), 256'd0);
      chk("rst_digest", digest, 256'd0);
      chk("rst_dvalid", 256'(digest_valid), 256'd0);
      chk("rst_timeout", 256'(timeout), 256'd0);
      chk("rst_addr_err", 256'(addr_err), 256'd0);
      chk("rst_sha_start", 256'(sha_start), 256'd0);
      chk("rst_rdata", 256'(mem_read_data), 256'd0);
      chk("msg_addr", 256'(sha_message_addr), 256'(MSG_BASE));
      chk("out_addr", 256'(sha_output_addr), 256'(OUT_BASE));
      go = 1'b1;
      @(negedge clk); @(negedge clk);
      chk("go_in_reset", 256'(busy), 256'd0);
      go = 1'b0; reset = 1'b0;
      @(negedge clk);
      hw(MSG_BASE, 32'h61626380);
      for (int i = 1; i < 15; i++) hw(MSG_BASE + 16'(i), 32'h0);
      hw(MSG_BASE + 16'd15, 32'h00000018);
      chk("addr_err_clean", 256'(addr_err), 256'd0);
      hw(16'h0100, 32'h12345678);
      chk("addr_err_oor", 256'(addr_err), 256'd1);
      // run 1: real hash of "abc", with a stray go mid-run
      n0 = n_start;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      chk("go_busy", 256'(busy), 256'd1);
      chk("start_not_yet", 256'(sha_start), 256'd0);
      repeat (SCRUB_CYC) @(negedge clk);
      @(negedge clk);
      chk("start_pulse", 256'(sha_start), 256'd1);
      run_hash(1'b1);
      cnt = 0;
      while (!digest_valid && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      chk("dv_latency", 256'(cnt), 256'd10);
      chk("done_busy", 256'(busy), 256'd0);
      chk("abc_digest", digest, ABC_EXP);
      chk("run_timeout", 256'(timeout), 256'd0);
      repeat (5) @(negedge clk);
      chk("go_not_queued", 256'(busy), 256'd0);
      chk("one_start", 256'(n_start - n0), 256'd1);
      // run 2: read/write ordering and stale or scrubbed digest region
      hw(16'h0005, 32'hA5A50005);
      for (int j = 0; j < 8; j++) hw(OUT_BASE + 16'(j), 32'hFFFFFFFF);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      repeat (SCRUB_CYC) @(negedge clk);
      @(negedge clk);
      chk("start_pulse2", 256'(sha_start), 256'd1);
      sha_done = 1'b0; mem_we = 1'b0; mem_addr = 16'h0005;
      @(negedge clk);
      chk("rd_old", 256'(mem_read_data), 256'(32'hA5A50005));
      mem_we = 1'b1; mem_write_data = 32'hDEADBEEF;
      @(negedge clk);
      chk("rd_hold_on_write", 256'(mem_read_data), 256'(32'hA5A50005));
      mem_we = 1'b0;
      @(negedge clk);
      chk("rd_new", 256'(mem_read_data), 256'(32'hDEADBEEF));
      mem_addr = 16'h0100;
      @(negedge clk);
      chk("rd_oor_zero", 256'(mem_read_data), 256'd0);
      mem_addr = 16'h0000; sha_done = 1'b1;
      cnt = 0;
      while (!digest_valid && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      chk("dv_run2", 256'(digest_valid), 256'd1);
      chk("digest_run2", digest, STALE_EXP);
      // timeout with a hasher whose done never drops
      go_t = 1'b1;
      @(negedge clk);
      go_t = 1'b0;
      cnt = 0;
      while (!t_sha_start && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      chk("t_start_seen", 256'(t_sha_start), 256'd1);
      repeat (16) @(negedge clk);
      chk("t_busy_16", 256'(t_busy), 256'd1);
      chk("t_timeout_16", 256'(t_timeout), 256'd0);
      @(negedge clk);
      chk("t_busy_17", 256'(t_busy), 256'd0);
      chk("t_timeout_17", 256'(t_timeout), 256'd1);
      chk("t_dvalid", 256'(t_digest_valid), 256'd0);
      // reset mid-run
      go_t = 1'b1;
      @(negedge clk);
      go_t = 1'b0;
      repeat (3) @(negedge clk);
      chk("t_busy_run", 256'(t_busy), 256'd1);
      reset = 1'b1;
      #1;
      chk("rst_mid_busy", 256'(t_busy), 256'd0);
      chk("rst_mid_timeout", 256'(t_timeout), 256'd0);
      chk("rst_addr_err", 256'(addr_err), 256'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
